// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive path.
// FSM state encoding and IO-page word bits for the RX device.
package uart_rx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int IO_UART_RX_DAT_bit  = 3;
  localparam int IO_UART_RX_CNTL_bit = 4;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: synchroniser, bit timer, receive FSM and shifter.
// Emits a one-cycle byte_valid pulse at the stop-bit sample point.
module uart_rx_core
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       RXD,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_ok
);

  localparam int TW =
    (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] HALF =
    TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL =
    TW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q;
  logic          rxs;
  rx_state_t     state_q, state_n;
  logic [TW-1:0] tmr_q, tmr_n;
  logic [2:0]    idx_q, idx_n;
  logic [7:0]    sh_q, sh_n;
  logic          expired;

  assign rxs     = sync_q[1];
  assign expired = (tmr_q == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RXD};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_n;
      tmr_q   <= tmr_n;
      idx_q   <= idx_n;
      sh_q    <= sh_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    tmr_n      = expired ? tmr_q : tmr_q - 1'b1;
    idx_n      = idx_q;
    sh_n       = sh_q;
    byte_valid = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (!rxs) begin
          tmr_n   = HALF;
          state_n = START;
        end
      end
      (state_q == START): begin
        if (expired) begin
          if (rxs) begin
            state_n = IDLE;
          end else begin
            tmr_n   = FULL;
            idx_n   = '0;
            state_n = DATA;
          end
        end
      end
      (state_q == DATA): begin
        if (expired) begin
          sh_n  = {rxs, sh_q[7:1]};
          tmr_n = FULL;
          idx_n = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_n = STOP;
          end
        end
      end
      (state_q == STOP): begin
        if (expired) begin
          byte_valid = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign byte_data = sh_q;
  assign stop_ok   = rxs;

endmodule

// File: rtl/uart_rx_fifo.sv
// Memory-mapped UART receiver with first-word-fall-through FIFO.
// Define UART_RX_FRAME_CHECK_EN to drop bytes with a low stop bit.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 1_000_000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          RXD,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          frame_err,
  input  logic                          clr_err
);

  localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef UART_RX_FRAME_CHECK_EN
  localparam bit FRAME_CHECK = 1'b1;
`else
  localparam bit FRAME_CHECK = 1'b0;
`endif

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          stop_ok;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push_req, push_ok, pop_ok;
  logic          ovr_set, frm_set;
  logic          ovr_q, frm_q;

  uart_rx_core #(
    .CLKS_PER_BIT (CPB)
  ) u_core (
    .clk        (clk),
    .resetn     (resetn),
    .RXD        (RXD),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_ok    (stop_ok)
  );

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A bad stop bit only blocks the push when frame checking is built in.
  assign push_req = byte_valid & (stop_ok | ~FRAME_CHECK);
  assign frm_set  = byte_valid & ~stop_ok & FRAME_CHECK;

  // Popping a full FIFO frees the slot the push lands in.
  assign pop_ok  = rd_en & ~empty;
  assign push_ok = push_req & (~full | rd_en);
  assign ovr_set = push_req & full & ~rd_en;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= byte_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovr_q <= 1'b0;
      frm_q <= 1'b0;
    end else begin
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (clr_err) begin
        ovr_q <= 1'b0;
      end
      if (frm_set) begin
        frm_q <= 1'b1;
      end else if (clr_err) begin
        frm_q <= 1'b0;
      end
    end
  end

  assign rd_data   = empty ? 8'h00 : mem[rd_ptr];
  assign rx_valid  = ~empty;
  assign rx_count  = count;
  assign overrun   = ovr_q;
  assign frame_err = frm_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// 10 clocks per bit, 4-entry FIFO.
module tb_uart_rx_fifo;

  logic       clk;
  logic       resetn;
  logic       RXD;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       overrun;
  logic       frame_err;
  logic       clr_err;

  int checks;
  int errors;

  uart_rx_fifo #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD_RATE   (100_000),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .RXD       (RXD),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rx_valid  (rx_valid),
    .rx_count  (rx_count),
    .overrun   (overrun),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // 100-cycle frame; rd_en pulses at iteration pop_at (-1 for none).
  task automatic send_frame(
    input  logic [7:0] b,
    input  logic       stop,
    input  int         pop_at,
    output logic       v97,
    output logic       v98
  );
    int s;
    v97 = 1'b0;
    v98 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 97) v97 = rx_valid;
      if (i == 98) v98 = rx_valid;
      s = i / 10;
      if (s == 0) RXD = 1'b0;
      else if (s == 9) RXD = stop;
      else RXD = b[s-1];
      rd_en = (i == pop_at);
    end
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clear();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle(3);
    checks++;
    if (rx_valid !== 1'b0 || rx_count !== 3'd0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: valid=%b count=%0d data=%02h required 0/0/00",
               rx_valid, rx_count, rd_data);
    end
    checks++;
    if (overrun !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ovr=%b frm=%b required 0/0", overrun, frame_err);
    end
    resetn = 1'b1;
    idle(3);
  endtask

  task automatic test_single();
    logic v97, v98;
    send_frame(8'h55, 1'b1, -1, v97, v98);
    checks++;
    if (v97 !== 1'b0 || v98 !== 1'b1) begin
      errors++;
      $display("FAIL push_latency: v97=%b v98=%b required 0/1", v97, v98);
    end
    idle(2);
    checks++;
    if (rx_valid !== 1'b1 || rd_data !== 8'h55 || rx_count !== 3'd1) begin
      errors++;
      $display("FAIL single_frame: valid=%b data=%02h count=%0d required 1/55/1",
               rx_valid, rd_data, rx_count);
    end
    pop();
    checks++;
    if (rx_valid !== 1'b0 || rd_data !== 8'h00 || rx_count !== 3'd0) begin
      errors++;
      $display("FAIL single_pop: valid=%b data=%02h count=%0d required 0/00/0",
               rx_valid, rd_data, rx_count);
    end
    pop();
    checks++;
    if (rx_count !== 3'd0) begin
      errors++;
      $display("FAIL empty_pop: count=%0d required 0", rx_count);
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    RXD = 1'b0;
    idle(3);
    RXD = 1'b1;
    idle(30);
    checks++;
    if (rx_count !== 3'd0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch: count=%0d valid=%b required 0/0", rx_count, rx_valid);
    end
  endtask

  task automatic test_overrun();
    logic v97, v98;
    logic [7:0] exp;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, -1, v97, v98);
    end
    idle(2);
    checks++;
    if (rx_count !== 3'd4 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_fill: count=%0d ovr=%b required 4/1", rx_count, overrun);
    end
    for (int k = 1; k <= 4; k++) begin
      exp = 8'(k);
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("FAIL overrun_pop%0d: data=%02h required %02h", k, rd_data, exp);
      end
      pop();
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_drain: valid=%b required 0", rx_valid);
    end
    clear();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: ovr=%b required 0", overrun);
    end
  endtask

  task automatic test_frame_err();
    logic v97, v98;
    send_frame(8'hA3, 1'b0, -1, v97, v98);
    RXD = 1'b1;
    idle(20);
`ifdef UART_RX_FRAME_CHECK_EN
    checks++;
    if (frame_err !== 1'b1 || rx_count !== 3'd0) begin
      errors++;
      $display("FAIL frame_err: frm=%b count=%0d required 1/0", frame_err, rx_count);
    end
    clear();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_clear: frm=%b required 0", frame_err);
    end
`else
    checks++;
    if (rd_data !== 8'hA3 || frame_err !== 1'b0 || rx_count !== 3'd1) begin
      errors++;
      $display("FAIL frame_nocheck: data=%02h frm=%b count=%0d required A3/0/1",
               rd_data, frame_err, rx_count);
    end
    pop();
`endif
  endtask

  task automatic test_full_pop();
    logic v97, v98;
    for (int k = 0; k < 4; k++) begin
      send_frame(8'h10 + 8'(k), 1'b1, -1, v97, v98);
    end
    send_frame(8'h14, 1'b1, 97, v97, v98);
    idle(2);
    checks++;
    if (rx_count !== 3'd4 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL full_pop: count=%0d ovr=%b required 4/0", rx_count, overrun);
    end
    checks++;
    if (rd_data !== 8'h11) begin
      errors++;
      $display("FAIL full_pop_head: data=%02h required 11", rd_data);
    end
  endtask

  task automatic test_reset_mid();
    logic v97, v98;
    send_frame(8'h77, 1'b1, -1, v97, v98);
    idle(2);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_ovr: ovr=%b required 1", overrun);
    end
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      RXD = (i < 10) ? 1'b0 : 1'b1;
    end
    resetn = 1'b0;
    idle(3);
    checks++;
    if (rx_count !== 3'd0 || overrun !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: count=%0d ovr=%b data=%02h required 0/0/00",
               rx_count, overrun, rd_data);
    end
    resetn = 1'b1;
    idle(5);
    send_frame(8'h3C, 1'b1, -1, v97, v98);
    idle(20);
    checks++;
    if (rx_count !== 3'd1 || rd_data !== 8'h3C) begin
      errors++;
      $display("FAIL post_reset: count=%0d data=%02h required 1/3C", rx_count, rd_data);
    end
    checks++;
    if (overrun !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_flags: ovr=%b frm=%b required 0/0", overrun, frame_err);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    resetn  = 1'b0;
    RXD     = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_overrun();
    test_frame_err();
    test_full_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Memory-mapped UART receiver for the SOC IO page: deserialises 8N1 frames arriving on `RXD` and buffers received bytes in a small FIFO that the processor drains through the IO read path. It is the inbound counterpart of the UART emitter and lets firmware poll for input instead of leaving `RXD` unconnected.

## Interface

Parameters:
- `CLK_FREQ_HZ`, default 100_000_000: frequency of `clk`.
- `BAUD_RATE`, default 1_000_000: line rate. `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE` (integer division), which must be ≥ 4.
- `FIFO_DEPTH`, default 8: number of FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: active-low reset, asynchronous assert.
- `RXD` in 1: asynchronous serial input; idle level is high.
- `rd_en` in 1: pop strobe, one cycle wide.
- `rd_data` out 8: byte at the FIFO head. Reads 0 when the FIFO is empty.
- `rx_valid` out 1: FIFO is not empty.
- `rx_count` out `$clog2(FIFO_DEPTH)+1`: current occupancy.
- `overrun` out 1: sticky; a byte was lost because the FIFO was full.
- `frame_err` out 1: sticky; a stop bit was sampled low.
- `clr_err` in 1: clears `overrun` and `frame_err`.

## Operation

Input conditioning:
- `RXD` passes through a 2-flop synchroniser, reset to 1. Its output is `rxs`.

Receiver FSM, states `IDLE`, `START`, `DATA`, `STOP`:
- **IDLE:** when `rxs` = 0, load the bit timer with `CLKS_PER_BIT/2 - 1` and go to `START`.
- **START:** when the timer expires, sample `rxs`.
  - `rxs` = 1: false start; return to `IDLE`, nothing is pushed.
  - `rxs` = 0: load the timer with `CLKS_PER_BIT - 1`, clear the bit index, go to `DATA`.
- **DATA:** at each timer expiry, shift `rxs` into the shift register LSB-first and reload the timer. After bit index 7, go to `STOP`.
- **STOP:** at timer expiry, sample the stop bit, issue the push request, and return to `IDLE` on the same edge.

FIFO:
- First-word-fall-through: `rd_data = mem[rd_ptr]`.
- Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally.
- Push is ignored when full and sets `overrun`.
- Pop is ignored when empty.
- Push and pop in the same cycle when full: both take effect, count is unchanged, no overrun.
- Push and pop in the same cycle when empty: the push takes effect, the pop is ignored.
- `clr_err` in the same cycle as a new error event: the set wins.

Reset:
- Asynchronous reset returns FSM to `IDLE`, clears pointers, count and flags, and sets the synchroniser to 1. Any partial frame is discarded.
- After reset, a line held low is treated as a new start edge.
- Reset values: `rx_valid` = 0, `rx_count` = 0, `rd_data` = 0, `overrun` = 0, `frame_err` = 0.

## Timing

- Start detection: `IDLE` sees the falling edge 2 cycles after `RXD` falls, because of the synchroniser.
- Sample points:
  - Start-bit check at T0 + `CLKS_PER_BIT/2`, where T0 is the cycle `IDLE` sees the falling edge.
  - Data bit *k* at T0 + `CLKS_PER_BIT/2` + (*k*+1)·`CLKS_PER_BIT`.
  - Stop bit at T0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- Push latency: `rx_valid` and `rd_data` update on the clock edge after the stop sample.
- Back-to-back frames: a new start bit is accepted on the cycle after the `STOP` exit.
- Pop: `rd_en` sampled at edge N makes the next byte (or 0 if now empty) visible after edge N. `rx_count` updates on the same edge.
- Sticky flags: set on the edge after the push attempt. Cleared on the edge after `clr_err`.

## Configuration

`UART_RX_FRAME_CHECK_EN` controls stop-bit checking:
- **Defined:** a stop bit sampled low sets `frame_err` and the byte is NOT pushed.
- **Undefined:** the stop bit is not checked, every completed frame is pushed, and `frame_err` is tied to 0.

## Structure

- Shared package: FSM state localparams (`IDLE` = 0, `START` = 1, `DATA` = 2, `STOP` = 3) and the IO-page word bits for this device:
  - `IO_UART_RX_DAT_bit` = 3: read pops.
  - `IO_UART_RX_CNTL_bit` = 4: status `{overrun, frame_err, rx_count, rx_valid}`.
- Sub-module `uart_rx_core`: synchroniser, bit timer, FSM and shift register. Its outputs are `byte_valid` (1-cycle pulse), `byte_data` and `stop_ok`.
- The FIFO and flags are inline in `uart_rx_fifo`.

## Test plan

Bench parameters: `CLK_FREQ_HZ` = 1_000_000, `BAUD_RATE` = 100_000 (10 clocks/bit), `FIFO_DEPTH` = 4.

1. Single frame 0x55 → `rx_valid` = 1, `rd_data` = 0x55, `rx_count` = 1. Then one `rd_en` pulse → `rx_valid` = 0, `rd_data` = 0.
2. Glitch: `RXD` low for 3 cycles → stays in `IDLE`, `rx_count` = 0.
3. Five back-to-back frames 0x01..0x05 with no reads → `rx_count` = 4, `overrun` = 1, pops return 0x01..0x04. Then `clr_err` → `overrun` = 0.
4. Frame 0xA3 with stop bit = 0:
   - With the macro: `frame_err` = 1, `rx_count` = 0.
   - Without the macro: `rd_data` = 0xA3, `frame_err` = 0.
5. FIFO full (4 bytes), then a 5th frame whose push coincides with `rd_en` → `rx_count` stays 4, `overrun` = 0, head advances to the 2nd byte.
6. `resetn` asserted mid-`DATA` of 0xFF, released, then frame 0x3C sent → only 0x3C is received, `rx_count` = 1, flags = 0.
